fb_write_scheduler: RTL and testbench
=====================================

FB_WRITE_SCHEDULER -- requirements
Module: fb_write_scheduler

Interface
REQ-001 SHALL have parameter RESOLUTION_H, default 1280, visible pixels per line.
REQ-002 SHALL have parameter RESOLUTION_V, default 960, visible lines per frame.
REQ-003 SHALL have parameter HPOS_WIDTH, default 11, horizontal coordinate width.
REQ-004 SHALL have parameter VPOS_WIDTH, default 10, vertical coordinate width.
REQ-005 SHALL have parameter ADDR_WIDTH, default 21, framebuffer word address width; the integrator sets it to at least clog2(RESOLUTION_H*RESOLUTION_V).
REQ-006 SHALL have one clock and a synchronous active-high reset, ports: clk in 1, rising-edge clock; rst in 1, synchronous active-high reset.
REQ-007 SHALL have ports req0_valid in 1, req0_hpos in HPOS_WIDTH, req0_vpos in VPOS_WIDTH, req0_rgb in 3, req0_ready out 1: pixel-write requester 0.
REQ-008 SHALL have an identical port set req1_* for requester 1.
REQ-009 SHALL have ports fifo_push out 1, fifo_hpos_write out HPOS_WIDTH, fifo_vpos_write out VPOS_WIDTH, fifo_rgb_write out 3, fifo_full in 1: pixel FIFO write side.
REQ-010 SHALL have ports fifo_pop out 1, fifo_hpos_read in HPOS_WIDTH, fifo_vpos_read in VPOS_WIDTH, fifo_rgb_read in 3, fifo_empty in 1: pixel FIFO read side; the head entry is valid whenever fifo_empty=0.
REQ-011 SHALL have ports mem_busy in 1, mem_we out 1, mem_addr out ADDR_WIDTH, mem_data out 3: framebuffer write port; mem_busy=1 while the display scan-out owns the memory.
REQ-012 SHALL have port drop_count out 8: saturating count of discarded off-screen pixels.

Function
REQ-013 Arbiter SHALL be round-robin between req0 and req1, using a 1-bit priority pointer prio (0 = req0 preferred).
REQ-014 Arbiter: when fifo_full=0, reqN_ready SHALL be 1 for the granted requester only; grant goes to the prio-preferred requester if its valid=1, else to the other requester if its valid=1; with neither valid, ready follows prio.
REQ-015 Arbiter: when fifo_full=1, both req0_ready and req1_ready SHALL be 0.
REQ-016 fifo_push SHALL equal (granted valid AND ready), combinationally; fifo_*_write SHALL carry the granted requester's fields in the same cycle (zero-latency pass-through).
REQ-017 After each accepted push, prio SHALL point to the requester that was not served; prio SHALL be unchanged when no push occurs.
REQ-018 Drain FSM SHALL have two states, D_IDLE and D_WRITE.
REQ-019 In D_IDLE, when fifo_empty=0 and mem_busy=0, the block SHALL assert fifo_pop for exactly that cycle, register the head hpos/vpos/rgb, and go to D_WRITE; otherwise fifo_pop=0 and the state remains D_IDLE.
REQ-020 In D_WRITE, for an on-screen pixel (hpos<RESOLUTION_H and vpos<RESOLUTION_V), the block SHALL drive mem_we=1, mem_addr=vpos*RESOLUTION_H+hpos (computed at full ADDR_WIDTH, no truncation of the product), and mem_data=rgb, for one cycle; it then returns to D_IDLE.
REQ-021 In D_WRITE, an off-screen pixel SHALL give mem_we=0 and increment drop_count, saturating at 255; the state then returns to D_IDLE.
REQ-022 mem_we SHALL be 0 in D_IDLE; mem_addr/mem_data hold their last values when mem_we=0.
REQ-023 A mem_busy rise during D_WRITE SHALL NOT abort the write already in progress; mem_busy is sampled only in D_IDLE.
REQ-024 Drain throughput SHALL be one pixel per two cycles; end-to-end latency SHALL be at least 3 cycles from an accepted request to mem_we, as the FIFO adds at least 1 cycle.
REQ-025 Push and pop in the same cycle SHALL be permitted; the block SHALL never push when fifo_full=1 or pop when fifo_empty=1.

Reset
REQ-026 With rst=1 at a clk edge, the block SHALL set: state D_IDLE, prio 0, drop_count 0, mem_we 0, mem_addr 0, mem_data 0, captured pixel registers 0.
REQ-027 While rst=1, fifo_push=0, fifo_pop=0, req0_ready=0 and req1_ready=0.
REQ-028 Reset asserted in D_WRITE SHALL suppress that write, so mem_we=0 in the next cycle; the popped pixel is lost.

Verification
REQ-029 Single pixel: req0 sends (hpos=5, vpos=2, rgb=3'b101), FIFO empty, mem_busy=0 -> one fifo_push, then one fifo_pop, then mem_we=1 with mem_addr=2565 and mem_data=5.
REQ-030 Both requesters valid continuously, FIFO not full -> grants alternate req0, req1, req0, ...; no requester is granted twice in a row.
REQ-031 fifo_full=1 with both valid -> both ready=0 and fifo_push=0; after fifo_full drops, the grant goes to the prio-preferred requester.
REQ-032 FIFO holds 3 entries, mem_busy=1 for 10 cycles -> no fifo_pop and no mem_we; after mem_busy=0, 3 writes occur on alternate cycles.
REQ-033 Pixels (1280,0) and (0,960) -> both are popped, mem_we stays 0, drop_count=2; 300 off-screen pixels -> drop_count=255.
REQ-034 rst asserted in the D_WRITE cycle -> mem_we=0 and all reset values from REQ-026 hold on the next edge.

Source files
------------

// File: rtl/fb_write_scheduler.sv
// Pixel-write scheduler: round-robin arbitration of two requesters into a pixel FIFO,
// and a two-state drain that writes on-screen pixels into the framebuffer.
module fb_write_scheduler #(
    parameter int RESOLUTION_H = 1280,
    parameter int RESOLUTION_V = 960,
    parameter int HPOS_WIDTH   = 11,
    parameter int VPOS_WIDTH   = 10,
    parameter int ADDR_WIDTH   = 21
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    input  logic [HPOS_WIDTH-1:0] req0_hpos,
    input  logic [VPOS_WIDTH-1:0] req0_vpos,
    input  logic [2:0]            req0_rgb,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [HPOS_WIDTH-1:0] req1_hpos,
    input  logic [VPOS_WIDTH-1:0] req1_vpos,
    input  logic [2:0]            req1_rgb,
    output logic                  req1_ready,
    output logic                  fifo_push,
    output logic [HPOS_WIDTH-1:0] fifo_hpos_write,
    output logic [VPOS_WIDTH-1:0] fifo_vpos_write,
    output logic [2:0]            fifo_rgb_write,
    input  logic                  fifo_full,
    output logic                  fifo_pop,
    input  logic [HPOS_WIDTH-1:0] fifo_hpos_read,
    input  logic [VPOS_WIDTH-1:0] fifo_vpos_read,
    input  logic [2:0]            fifo_rgb_read,
    input  logic                  fifo_empty,
    input  logic                  mem_busy,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [2:0]            mem_data,
    output logic [7:0]            drop_count
);

    typedef enum logic {D_IDLE, D_WRITE} drain_state_t;

    localparam logic [HPOS_WIDTH:0] H_LIMIT = (HPOS_WIDTH+1)'(RESOLUTION_H);
    localparam logic [VPOS_WIDTH:0] V_LIMIT = (VPOS_WIDTH+1)'(RESOLUTION_V);

    drain_state_t          state;
    logic                  prio;
    logic                  grant;
    logic                  grant_valid;
    logic [HPOS_WIDTH-1:0] cap_hpos;
    logic [VPOS_WIDTH-1:0] cap_vpos;
    logic [2:0]            cap_rgb;
    logic                  on_screen;
    logic [ADDR_WIDTH-1:0] pix_addr;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Grant the preferred requester when it is valid, otherwise fall over to the other one.
    always_comb begin
        grant = prio;
        if (prio ? req1_valid : req0_valid)
            grant = prio;
        else if (prio ? req0_valid : req1_valid)
            grant = ~prio;
        grant_valid = grant ? req1_valid : req0_valid;
    end

    assign req0_ready      = !rst && !fifo_full && !grant;
    assign req1_ready      = !rst && !fifo_full && grant;
    assign fifo_push       = !rst && !fifo_full && grant_valid;
    assign fifo_hpos_write = grant ? req1_hpos : req0_hpos;
    assign fifo_vpos_write = grant ? req1_vpos : req0_vpos;
    assign fifo_rgb_write  = grant ? req1_rgb  : req0_rgb;

    assign fifo_pop  = !rst && (state == D_IDLE) && !fifo_empty && !mem_busy;
    assign on_screen = ({1'b0, cap_hpos} < H_LIMIT) && ({1'b0, cap_vpos} < V_LIMIT);
    // Widen both operands before multiplying so the product is never truncated.
    assign pix_addr  = ADDR_WIDTH'(cap_vpos) * ADDR_WIDTH'(RESOLUTION_H) + ADDR_WIDTH'(cap_hpos);

    always_ff @(posedge clk) begin
        if (rst)
            prio <= 1'b0;
        else if (fifo_push)
            prio <= ~grant;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= D_IDLE;
            drop_count <= 8'd0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_data   <= 3'd0;
            cap_hpos   <= '0;
            cap_vpos   <= '0;
            cap_rgb    <= 3'd0;
        end else begin
            case (state)
                D_IDLE: begin
                    mem_we <= 1'b0;
                    if (fifo_pop) begin
                        cap_hpos <= fifo_hpos_read;
                        cap_vpos <= fifo_vpos_read;
                        cap_rgb  <= fifo_rgb_read;
                        state    <= D_WRITE;
                    end
                end
                D_WRITE: begin
                    // mem_busy is deliberately ignored here: a started write always completes.
                    if (on_screen) begin
                        mem_we   <= 1'b1;
                        mem_addr <= pix_addr;
                        mem_data <= cap_rgb;
                    end else begin
                        mem_we     <= 1'b0;
                        drop_count <= sat_inc(drop_count);
                    end
                    state <= D_IDLE;
                end
                default: begin
                    mem_we <= 1'b0;
                    state  <= D_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fb_write_scheduler.sv
// Directed bench for fb_write_scheduler with a behavioural pixel FIFO on the scheduler's FIFO ports.
module tb_fb_write_scheduler;

    localparam int HW = 11;
    localparam int VW = 10;
    localparam int AW = 21;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req1_valid;
    logic [HW-1:0] req0_hpos, req1_hpos;
    logic [VW-1:0] req0_vpos, req1_vpos;
    logic [2:0]    req0_rgb, req1_rgb;
    logic          req0_ready, req1_ready;
    logic          fifo_push, fifo_pop;
    logic [HW-1:0] fifo_hpos_write;
    logic [VW-1:0] fifo_vpos_write;
    logic [2:0]    fifo_rgb_write;
    logic          fifo_full;
    logic [HW-1:0] fifo_hpos_read = '0;
    logic [VW-1:0] fifo_vpos_read = '0;
    logic [2:0]    fifo_rgb_read = '0;
    logic          fifo_empty = 1'b1;
    logic          mem_busy;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [2:0]    mem_data;
    logic [7:0]    drop_count;

    logic [23:0] q[$];
    int checks = 0;
    int errors = 0;
    int pops, wes, pushes;

    always #5 clk = ~clk;

    fb_write_scheduler dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_hpos(req0_hpos), .req0_vpos(req0_vpos),
        .req0_rgb(req0_rgb), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_hpos(req1_hpos), .req1_vpos(req1_vpos),
        .req1_rgb(req1_rgb), .req1_ready(req1_ready),
        .fifo_push(fifo_push), .fifo_hpos_write(fifo_hpos_write),
        .fifo_vpos_write(fifo_vpos_write), .fifo_rgb_write(fifo_rgb_write),
        .fifo_full(fifo_full),
        .fifo_pop(fifo_pop), .fifo_hpos_read(fifo_hpos_read),
        .fifo_vpos_read(fifo_vpos_read), .fifo_rgb_read(fifo_rgb_read),
        .fifo_empty(fifo_empty),
        .mem_busy(mem_busy), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_data(mem_data), .drop_count(drop_count)
    );

    // Pixel FIFO: one cycle from push to visible head.
    always @(posedge clk) begin
        if (fifo_pop && q.size() > 0) void'(q.pop_front());
        if (fifo_push) q.push_back({fifo_hpos_write, fifo_vpos_write, fifo_rgb_write});
        fifo_empty <= (q.size() == 0);
        if (q.size() > 0) {fifo_hpos_read, fifo_vpos_read, fifo_rgb_read} <= q[0];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain_done", (q.size() == 0) ? 32'd1 : 32'd0, 32'd1);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; fifo_full = 1'b0; mem_busy = 1'b0;
        req0_valid = 1'b1; req0_hpos = 11'd9; req0_vpos = 10'd9; req0_rgb = 3'd1;
        req1_valid = 1'b1; req1_hpos = 11'd8; req1_vpos = 10'd8; req1_rgb = 3'd2;

        // Reset behaviour
        @(negedge clk); #1;
        chk("rst_req0_ready", req0_ready, 0);
        chk("rst_req1_ready", req1_ready, 0);
        chk("rst_push", fifo_push, 0);
        @(negedge clk); #1;
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_data", mem_data, 0);
        chk("rst_drop", drop_count, 0);

        // Single pixel (5,2,101) -> addr 2565
        @(negedge clk);
        rst = 1'b0; req1_valid = 1'b0;
        req0_hpos = 11'd5; req0_vpos = 10'd2; req0_rgb = 3'b101;
        #1;
        chk("single_ready0", req0_ready, 1);
        chk("single_push", fifo_push, 1);
        chk("single_hpos_w", fifo_hpos_write, 5);
        chk("single_vpos_w", fifo_vpos_write, 2);
        chk("single_rgb_w", fifo_rgb_write, 5);
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        chk("single_push_off", fifo_push, 0);
        chk("single_pop", fifo_pop, 1);
        chk("idle_ready1_prio", req1_ready, 1);
        chk("idle_ready0_prio", req0_ready, 0);
        @(negedge clk); #1;
        chk("single_pop_once", fifo_pop, 0);
        chk("single_we_wait", mem_we, 0);
        @(negedge clk); #1;
        chk("single_we", mem_we, 1);
        chk("single_addr", mem_addr, 2565);
        chk("single_data", mem_data, 5);
        @(negedge clk); #1;
        chk("single_we_drop", mem_we, 0);
        chk("single_addr_hold", mem_addr, 2565);

        // Round-robin with both valid; prio currently points at req1
        @(negedge clk);
        req0_valid = 1'b1; req0_hpos = 11'd10; req0_vpos = 10'd0; req0_rgb = 3'd1;
        req1_valid = 1'b1; req1_hpos = 11'd20; req1_vpos = 10'd0; req1_rgb = 3'd2;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_ready1", req1_ready, (i % 2 == 0) ? 1 : 0);
            chk("rr_ready0", req0_ready, (i % 2 == 0) ? 0 : 1);
            chk("rr_hpos_w", fifo_hpos_write, (i % 2 == 0) ? 20 : 10);
            chk("rr_push", fifo_push, 1);
            @(negedge clk);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_idle(50);

        // FIFO full blocks both requesters; prio is req1 again
        @(negedge clk);
        fifo_full = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("full_ready0", req0_ready, 0);
            chk("full_ready1", req1_ready, 0);
            chk("full_push", fifo_push, 0);
            @(negedge clk);
        end
        fifo_full = 1'b0;
        #1;
        chk("unfull_ready1", req1_ready, 1);
        chk("unfull_ready0", req0_ready, 0);
        chk("unfull_push", fifo_push, 1);
        chk("unfull_hpos_w", fifo_hpos_write, 20);
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_idle(50);

        // Three queued pixels held off by mem_busy, then drained on alternate cycles
        @(negedge clk);
        mem_busy = 1'b1; req0_valid = 1'b1; req0_vpos = 10'd0;
        for (int i = 1; i <= 3; i++) begin
            req0_hpos = HW'(i); req0_rgb = 3'(i);
            #1;
            chk("busy_push", fifo_push, 1);
            @(negedge clk);
        end
        req0_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("busy_no_pop", fifo_pop, 0);
            chk("busy_no_we", mem_we, 0);
            @(negedge clk);
        end
        mem_busy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("drain_pop", fifo_pop, (i == 0 || i == 2 || i == 4) ? 1 : 0);
            chk("drain_we", mem_we, (i == 2 || i == 4 || i == 6) ? 1 : 0);
            if (i == 2 || i == 4 || i == 6) begin
                chk("drain_addr", mem_addr, 32'(i / 2));
                chk("drain_data", mem_data, 32'(i / 2));
            end
            @(negedge clk);
        end

        // Off-screen pixels (1280,0) and (0,960) are dropped
        pops = 0; wes = 0;
        req0_valid = 1'b1; req0_hpos = 11'd1280; req0_vpos = 10'd0; req0_rgb = 3'd7;
        #1;
        chk("off_push_h", fifo_push, 1);
        @(negedge clk);
        req0_hpos = 11'd0; req0_vpos = 10'd960;
        #1;
        chk("off_push_v", fifo_push, 1);
        if (fifo_pop) pops++;
        @(negedge clk);
        req0_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (fifo_pop) pops++;
            if (mem_we) wes++;
            @(negedge clk);
        end
        chk("off_pops", pops, 2);
        chk("off_no_we", wes, 0);
        chk("off_drop2", drop_count, 2);

        // 300 more off-screen pixels saturate the drop counter
        pushes = 0;
        req0_valid = 1'b1; req0_vpos = 10'd5;
        for (int i = 0; i < 300; i++) begin
            req0_hpos = HW'(1300 + i);
            #1;
            if (fifo_push) pushes++;
            @(negedge clk);
        end
        req0_valid = 1'b0;
        chk("sat_pushes", pushes, 300);
        wait_idle(2000);
        chk("sat_drop", drop_count, 255);

        // Reset during D_WRITE suppresses the write; pixel (7,1) would be addr 1287
        @(negedge clk);
        req0_valid = 1'b1; req0_hpos = 11'd7; req0_vpos = 10'd1; req0_rgb = 3'd6;
        #1;
        chk("rstw_push", fifo_push, 1);
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        chk("rstw_pop", fifo_pop, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstw_we_before", mem_we, 0);
        chk("rstw_pop_rst", fifo_pop, 0);
        @(negedge clk);
        rst = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("rstw_we", mem_we, 0);
        chk("rstw_addr", mem_addr, 0);
        chk("rstw_data", mem_data, 0);
        chk("rstw_drop", drop_count, 0);
        chk("rstw_prio0", req0_ready, 1);
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        chk("rstw_no_late_we", mem_we, 0);
        wait_idle(50);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
